// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC0809-style bus (controller and responder).
package adc_pkg;

    localparam int ADC_BITS = 8;
    localparam int NUM_CH   = 8;
    localparam int ADDR_W   = 3;

    // Converter states; ARMED waits for the trailing edge of start.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CONV  = 2'd2
    } adc_state_e;

    // One-hot mask for the SAR bit currently being resolved.
    function automatic logic [ADC_BITS-1:0] sar_bit(input logic [ADDR_W-1:0] idx);
        logic [ADC_BITS-1:0] one;
        one = ADC_BITS'(1);
        return one << idx;
    endfunction

endpackage

// File: rtl/adc0809_responder_if.sv
// ADC0809-style bus between the controller (master) and the emulated converter (slave).
// Handshake: the master raises start (optionally with ale) and drops it; eoc falls
// while a conversion is pending and rises once the code is latched. result is only
// meaningful while out_en is high; result_oe mirrors out_en as the tri-state enable.
interface adc0809_responder_if;
    import adc_pkg::*;

    logic                adc_clk;
    logic                ale;
    logic                start;
    logic                out_en;
    logic [ADDR_W-1:0]   addr;
    logic                eoc;
    logic [ADC_BITS-1:0] result;
    logic                result_oe;

    modport master (
        output adc_clk, ale, start, out_en, addr,
        input  eoc, result, result_oe
    );

    modport slave (
        input  adc_clk, ale, start, out_en, addr,
        output eoc, result, result_oe
    );

endinterface

// File: rtl/adc0809_responder_edge_det.sv
// Single-bit edge detector: one register holds the previous sample, edges are
// reported in the same cycle the new level appears on the input.
module edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic prev_q;
    logic prev_d;

    // Next value of the history register is simply the current input.
    always_comb begin
        prev_d = d;
    end

    // History register, cleared by the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = d & ~prev_q;
    assign fall = ~d & prev_q;

endmodule

// File: rtl/adc0809_responder.sv
// Emulated ADC0809: latches the channel address, runs an 8-bit successive-
// approximation search against a held digital sample, and reports with eoc.
module adc0809_responder
    import adc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    adc0809_responder_if.slave       bus,
    input  logic [NUM_CH*ADC_BITS-1:0] ch_data,
    output logic                     busy,
    output adc_state_e               dbg_state
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic ale_rise, ale_fall;
    logic start_rise, start_fall;
    logic adc_rise, adc_fall;

    edge_det u_ale_det (
        .clk   (clk),
        .reset (reset),
        .d     (bus.ale),
        .rise  (ale_rise),
        .fall  (ale_fall)
    );

    edge_det u_start_det (
        .clk   (clk),
        .reset (reset),
        .d     (bus.start),
        .rise  (start_rise),
        .fall  (start_fall)
    );

    edge_det u_adc_det (
        .clk   (clk),
        .reset (reset),
        .d     (bus.adc_clk),
        .rise  (adc_rise),
        .fall  (adc_fall)
    );

    adc_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   ch_sel_q, ch_sel_d;
    logic [ADC_BITS-1:0] hold_q, hold_d;
    logic [ADC_BITS-1:0] sar_q, sar_d;
    logic [ADDR_W-1:0]   bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic [ADC_BITS-1:0] result_reg_q, result_reg_d;
    logic [ADDR_W-1:0]   ch_sel_eff;
    logic [ADC_BITS-1:0] trial;

    // Next-state logic: address latch, start/abort handling and the SAR search.
    always_comb begin
        state_d      = state_q;
        ch_sel_d     = ch_sel_q;
        hold_d       = hold_q;
        sar_d        = sar_q;
        bit_idx_d    = bit_idx_q;
        edge_cnt_d   = edge_cnt_q;
        result_reg_d = result_reg_q;
        trial        = sar_q;

        // A same-cycle ale rise takes effect before the sample is selected.
        ch_sel_eff = ale_rise ? bus.addr : ch_sel_q;
        ch_sel_d   = ch_sel_eff;

        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (start_rise) begin
                    state_d = ARMED;
                end else if (start_fall) begin
                    state_d    = CONV;
                    hold_d     = ch_data[{ch_sel_eff, 3'b000} +: ADC_BITS];
                    sar_d      = 8'h80;
                    bit_idx_d  = 3'd7;
                    edge_cnt_d = '0;
                end
            end
            CONV: begin
                if (start_rise) begin
                    // Restart: wait for the new start pulse to end.
                    state_d = ARMED;
                end else if (adc_rise) begin
                    if (edge_cnt_q == CNT_LAST) begin
                        edge_cnt_d = '0;
                        if (sar_q > hold_q) begin
                            trial = sar_q & ~sar_bit(bit_idx_q);
                        end
                        if (bit_idx_q == 3'd0) begin
                            sar_d        = trial;
                            result_reg_d = trial;
                            state_d      = IDLE;
                        end else begin
                            sar_d     = trial | sar_bit(bit_idx_q - 3'd1);
                            bit_idx_d = bit_idx_q - 3'd1;
                        end
                    end else begin
                        edge_cnt_d = edge_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            ch_sel_q     <= '0;
            hold_q       <= '0;
            sar_q        <= '0;
            bit_idx_q    <= '0;
            edge_cnt_q   <= '0;
            result_reg_q <= '0;
        end else begin
            state_q      <= state_d;
            ch_sel_q     <= ch_sel_d;
            hold_q       <= hold_d;
            sar_q        <= sar_d;
            bit_idx_q    <= bit_idx_d;
            edge_cnt_q   <= edge_cnt_d;
            result_reg_q <= result_reg_d;
        end
    end

    assign bus.eoc       = (state_q == IDLE);
    assign bus.result    = bus.out_en ? result_reg_q : '0;
    assign bus.result_oe = bus.out_en;
    assign busy          = (state_q != IDLE);
    assign dbg_state     = state_q;

endmodule

// File: doc/adc0809_responder.md
# adc0809_responder

Synthesizable responder for the ADC0809-style bus driven by our ADC controller (start/ale/out_en/adc_clk/addr in, eoc/result out). It emulates the converter chip: latches the channel address, runs a cycle-accurate successive-approximation conversion on a digital per-channel sample bus, and returns the code with EOC handshaking. It lets the ADC/FND/motor chain run on the board or in simulation without the analog front end.

## Interface
Parameters:
- CLKS_PER_BIT, 8, adc_clk rising edges spent resolving each SAR bit (total conversion = 8*CLKS_PER_BIT edges, 64 by default)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset
- adc_clk  input  1  converter clock from controller, generated in the clk domain
- ale  input  1  address latch enable
- start  input  1  conversion start
- out_en  input  1  output enable
- addr  input  3  channel select
- ch_data  input  64  emulated analog values; channel k = ch_data[8k+7:8k]
- eoc  output  1  end of conversion; high when idle or done
- result  output  8  converted code when out_en=1, else 8'h00
- result_oe  output  1  equals out_en; marks result as driven (tri-state model)
- busy  output  1  high in ARMED or CONV

## Operation
- Inputs are already in the clk domain; no synchronizers. Each of ale, start, adc_clk is registered once; rise = cur & ~prev, fall = ~cur & prev.
- ale rise: ch_sel <= addr. Allowed in any state; does not affect a conversion already in CONV.
- States: IDLE, ARMED, CONV.
- IDLE: eoc=1. start rise -> ARMED, eoc <= 0.
- ARMED: waits for start fall -> CONV; on that edge hold <= selected channel of ch_data (using ch_sel as updated in that same cycle), sar <= 8'h80, bit_idx <= 7, edge_cnt <= 0.
- CONV: counts adc_clk rises. On each rise edge_cnt increments; when edge_cnt reaches CLKS_PER_BIT-1 the current bit is decided: keep bit if sar <= hold else clear it; then set next lower bit, bit_idx decrements, edge_cnt <= 0. After bit 0 is decided: result_reg <= final sar, eoc <= 1, -> IDLE.
- Final code always equals hold (exact 8-bit SAR, no quantization error).
- start rise in ARMED or CONV: abort, remain/return to ARMED, eoc stays 0, result_reg unchanged.
- ale and start rising in the same cycle: address latched first, conversion uses new address.
- out_en=1 at any time drives result_reg (last completed code), including during CONV.

## Timing
- Reset (reset=0 at a clk edge): state IDLE, eoc=1, result=8'h00, result_reg=0, result_oe follows out_en (0 when out_en=0), busy=0, ch_sel=0, edge registers cleared.
- start rise visible on input at edge N -> eoc=0, busy=1 after edge N.
- Sample taken at the edge where start fall is detected; later ch_data changes ignored.
- eoc rises after the edge on which the (8*CLKS_PER_BIT)-th adc_clk rise following start fall is detected; result_reg valid from that same edge.
- result and result_oe are combinational from out_en and result_reg (zero added latency).
- adc_clk rises in ARMED or IDLE are ignored. adc_clk high/low phases must each last >= 1 clk.
- Reset mid-conversion: aborts immediately, outputs to reset values.

## Structure
- Package adc_pkg: state enum (IDLE, ARMED, CONV), ADC_BITS=8, NUM_CH=8, ADDR_W=3; shared with the controller.
- One sub-module: edge_det (registered rise/fall detector, 1 bit), instantiated for ale, start, adc_clk.
- SAR datapath and FSM stay in the top module.

## Test plan
- Reset: hold reset=0 two cycles with out_en=1 -> eoc=1, result=8'h00, busy=0.
- Basic: ch3=8'hA5, ale+start pulse with addr=3, adc_clk period 4 clk -> eoc low within one cycle, high exactly 64 adc_clk rises after start fall; out_en -> result=8'hA5.
- Boundary codes: ch0=8'h00, ch7=8'hFF, ch5=8'h80 -> results 8'h00, 8'hFF, 8'h80.
- Sample hold: change ch3 from 8'h3C to 8'hC3 mid-conversion -> result=8'h3C; ale with addr=6 mid-conversion -> current result unaffected, next conversion reads ch6.
- Restart/abort: second start pulse after 20 adc_clk rises -> eoc stays 0, completion 64 rises after second start fall, prior result_reg visible via out_en meanwhile.
- Reset mid-conversion at rise 30 -> eoc=1, result_reg=0 next cycle; subsequent conversion completes normally; CLKS_PER_BIT=2 variant completes in 16 rises.
